// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic unit and its writeback stage:
// default widths, opcode encoding and writeback FSM state encoding.
package arith_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_REG_ADDR_W = 3;

  // Opcodes 1xx are reserved and retire as errors without a register write.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WR_LO = 2'd1;
  localparam logic [1:0] ST_WR_HI = 2'd2;

  function automatic logic is_reserved_op(input logic [2:0] opcode);
    return opcode[2];
  endfunction

endpackage

// File: rtl/arith_flag_gen.sv
// Combinational status-flag generator for a result/opcode pair about to
// retire: zero over the full width, non-zero high half, reserved opcode.
module arith_flag_gen
  import arith_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [2*DATA_W-1:0] result,
  input  logic [2:0]          opcode,
  output logic                zero,
  output logic                hi,
  output logic                err
);

  assign zero = (result == '0);
  assign hi   = (result[2*DATA_W-1:DATA_W] != '0);
  assign err  = is_reserved_op(opcode);

endmodule

// File: rtl/arith_wb_stage.sv
// Writeback stage behind the arithmetic unit: retires one result per op into
// the register file (two beats for multiply) and keeps sticky status flags.
module arith_wb_stage
  import arith_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*DATA_W-1:0]   in_result,
  input  logic [2:0]            in_opcode,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  flag_zero,
  output logic                  flag_hi,
  output logic                  flag_err,
  output logic                  busy
);

  logic [1:0]            state, nxt_state;
  logic [2*DATA_W-1:0]   hold_result, nxt_result;
  logic [2:0]            hold_op, nxt_op;
  logic [REG_ADDR_W-1:0] hold_rd, nxt_rd;
  logic                  hs;

  logic                  gen_zero, gen_hi, gen_err;
  logic                  we_d, zero_d, hi_d, err_d;
  logic [REG_ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0]     data_d;

  // Only the first beat of a multiply blocks: its second beat must follow.
  assign in_ready = (state == ST_IDLE) || (state == ST_WR_HI) ||
                    ((state == ST_WR_LO) && (hold_op != OP_MUL));
  assign hs       = in_valid && in_ready;
  assign busy     = (state != ST_IDLE);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    nxt_result = hold_result;
    nxt_op     = hold_op;
    nxt_rd     = hold_rd;
    nxt_state  = ST_IDLE;
    if (hs) begin
      nxt_result = in_result;
      nxt_op     = in_opcode;
      nxt_rd     = in_rd;
      nxt_state  = ST_WR_LO;
    end else if ((state == ST_WR_LO) && (hold_op == OP_MUL)) begin
      nxt_state = ST_WR_HI;
    end
  end

  // Flags are evaluated on the values that will be held next cycle, so the
  // registered outputs line up with the write they describe.
  arith_flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
    .result (nxt_result),
    .opcode (nxt_op),
    .zero   (gen_zero),
    .hi     (gen_hi),
    .err    (gen_err)
  );

  always_comb begin
    we_d   = 1'b0;
    addr_d = '0;
    data_d = '0;
    zero_d = flag_zero;
    hi_d   = flag_hi;
    err_d  = 1'b0;
    case (nxt_state)
      ST_WR_LO: begin
        if (gen_err) begin
          err_d = 1'b1;
        end else begin
          we_d   = 1'b1;
          addr_d = nxt_rd;
          data_d = nxt_result[DATA_W-1:0];
          zero_d = gen_zero;
          hi_d   = gen_hi;
        end
      end
      ST_WR_HI: begin
        we_d   = 1'b1;
        addr_d = nxt_rd + 1'b1;
        data_d = nxt_result[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase
  end

  // NOTE: state and outputs use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      hold_result <= '0;
      hold_op     <= '0;
      hold_rd     <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      flag_zero   <= 1'b0;
      flag_hi     <= 1'b0;
      flag_err    <= 1'b0;
    end else begin
      state       <= nxt_state;
      hold_result <= nxt_result;
      hold_op     <= nxt_op;
      hold_rd     <= nxt_rd;
      rf_we       <= we_d;
      rf_waddr    <= addr_d;
      rf_wdata    <= data_d;
      flag_zero   <= zero_d;
      flag_hi     <= hi_d;
      flag_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_arith_wb_stage.sv
// Directed bench for arith_wb_stage: reset, add, wrapped mul, back-to-back
// stream, reserved opcode and reset in the middle of a multiply.
module tb_arith_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [2:0]  in_opcode;
  logic [2:0]  in_rd;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        flag_zero, flag_hi, flag_err, busy;

  int checks   = 0;
  int failures = 0;
  int wr6_cnt  = 0;
  int wr6_base;

  arith_wb_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .flag_zero (flag_zero),
    .flag_hi   (flag_hi),
    .flag_err  (flag_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Counts register-file writes to r6 as the register file would sample them.
  always @(posedge clk) if (rf_we && rf_waddr == 3'd6) wr6_cnt <= wr6_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] res,
                       input logic [2:0] rd);
    in_valid  = v;
    in_opcode = op;
    in_result = res;
    in_rd     = rd;
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [2:0] addr,
                          input logic [15:0] data);
    check({tag, ".we"},   rf_we,    we);
    check({tag, ".addr"}, rf_waddr, addr);
    check({tag, ".data"}, rf_wdata, data);
  endtask

  task automatic check_flags(input string tag, input logic z, input logic h, input logic e);
    check({tag, ".zero"}, flag_zero, z);
    check({tag, ".hi"},   flag_hi,   h);
    check({tag, ".err"},  flag_err,  e);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'b000, 32'h0, 3'd0);
    step();
    step();
    check_wr("rst", 1'b0, 3'd0, 16'h0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    check("rst.busy", busy, 1'b0);
    rst = 1'b0;
    step();
    check("idle.ready", in_ready, 1'b1);
    check("idle.busy", busy, 1'b0);

    // Add retire
    drive(1'b1, 3'b000, 32'h0000_1234, 3'd2);
    step();
    drive(1'b0, 3'b000, 32'h0, 3'd0);
    check_wr("add", 1'b1, 3'd2, 16'h1234);
    check_flags("add", 1'b0, 1'b0, 1'b0);
    check("add.ready", in_ready, 1'b1);
    check("add.busy", busy, 1'b1);
    step();
    check_wr("add_idle", 1'b0, 3'd0, 16'h0);
    check("add_idle.busy", busy, 1'b0);

    // Mul two-beat with wrap from r7 to r0
    drive(1'b1, 3'b001, 32'hABCD_0123, 3'd7);
    step();
    drive(1'b0, 3'b000, 32'h0, 3'd0);
    check_wr("mul_lo", 1'b1, 3'd7, 16'h0123);
    check_flags("mul_lo", 1'b0, 1'b1, 1'b0);
    check("mul_lo.ready", in_ready, 1'b0);
    step();
    check_wr("mul_hi", 1'b1, 3'd0, 16'hABCD);
    check("mul_hi.ready", in_ready, 1'b1);
    step();
    check_wr("mul_idle", 1'b0, 3'd0, 16'h0);
    check_flags("mul_idle", 1'b0, 1'b1, 1'b0);

    // Reserved opcode: no write, one-cycle err, sticky flags untouched
    drive(1'b1, 3'b101, 32'h0, 3'd2);
    step();
    drive(1'b0, 3'b000, 32'h0, 3'd0);
    check_wr("inv", 1'b0, 3'd0, 16'h0);
    check_flags("inv", 1'b0, 1'b1, 1'b1);
    step();
    check_flags("inv_after", 1'b0, 1'b1, 1'b0);

    // Back-to-back stream with one stall behind the mul
    drive(1'b1, 3'b010, 32'h0000_0000, 3'd1);
    step();
    check_wr("b2b_sub", 1'b1, 3'd1, 16'h0000);
    check_flags("b2b_sub", 1'b1, 1'b0, 1'b0);
    check("b2b_sub.ready", in_ready, 1'b1);
    drive(1'b1, 3'b011, 32'h0000_0005, 3'd3);
    step();
    check_wr("b2b_div", 1'b1, 3'd3, 16'h0005);
    check_flags("b2b_div", 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'b001, 32'h0002_0004, 3'd4);
    step();
    check_wr("b2b_mul_lo", 1'b1, 3'd4, 16'h0004);
    check_flags("b2b_mul_lo", 1'b0, 1'b1, 1'b0);
    check("b2b_mul_lo.ready", in_ready, 1'b0);
    drive(1'b1, 3'b000, 32'h0000_0009, 3'd6);
    step();
    check_wr("b2b_mul_hi", 1'b1, 3'd5, 16'h0002);
    check("b2b_mul_hi.ready", in_ready, 1'b1);
    step();
    drive(1'b0, 3'b000, 32'h0, 3'd0);
    check_wr("b2b_add", 1'b1, 3'd6, 16'h0009);
    check_flags("b2b_add", 1'b0, 1'b0, 1'b0);
    step();
    check_wr("b2b_idle", 1'b0, 3'd0, 16'h0);
    check("b2b_idle.busy", busy, 1'b0);

    // Reset asserted during the WR_HI cycle of a mul to r5
    drive(1'b1, 3'b001, 32'h1111_2222, 3'd5);
    step();
    drive(1'b0, 3'b000, 32'h0, 3'd0);
    check_wr("rmid_lo", 1'b1, 3'd5, 16'h2222);
    step();
    wr6_base = wr6_cnt;
    rst = 1'b1;
    #1;
    check_wr("rmid_rst", 1'b0, 3'd0, 16'h0);
    check_flags("rmid_rst", 1'b0, 1'b0, 1'b0);
    check("rmid_rst.busy", busy, 1'b0);
    step();
    rst = 1'b0;
    step();
    step();
    check("rmid.no_wr6", wr6_cnt - wr6_base, 0);
    check_wr("rmid_idle", 1'b0, 3'd0, 16'h0);
    check("rmid_idle.busy", busy, 1'b0);
    check("rmid_idle.ready", in_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arith_wb_stage.md
Name: arith_wb_stage

Overview:
- Writeback stage directly downstream of the 16-bit arithmetic unit.
- Accepts the 32-bit arithmetic result plus the opcode and destination register, and writes it into the 16-bit register file.
- For multiply, both halves are written (low to rd, high to rd+1) over two cycles; for all other opcodes only the low half is written.
- Maintains sticky status flags and a valid/ready handshake back to the issue logic.

Parameters:
- DATA_W, 16, register-file word width; result width is 2*DATA_W.
- REG_ADDR_W, 3, register-file address width (8 registers).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  result/opcode/rd valid this cycle.
- in_ready  out  1  stage can accept; a transfer occurs when in_valid && in_ready.
- in_result  in  2*DATA_W  arithmetic-unit output.
- in_opcode  in  3  opcode that produced in_result.
- in_rd  in  REG_ADDR_W  destination register.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_ADDR_W  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- flag_zero  out  1  last retired result == 0 (all 32 bits).
- flag_hi  out  1  last retired result[31:16] != 0.
- flag_err  out  1  one-cycle pulse: an op with opcode 1xx retired.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE. rf_we, rf_waddr, rf_wdata, flag_zero, flag_hi, flag_err and busy are all 0. Captured operands are cleared. A pending write in progress is dropped and never completed.
- FSM states:
  - IDLE.
  - WR_LO.
  - WR_HI.
- Accept:
  - On a handshake, capture in_result, in_opcode and in_rd into holding registers.
  - Next state is WR_LO.
- WR_LO cycle:
  - For opcodes 000–011: rf_we=1, rf_waddr=rd, rf_wdata=result[15:0].
  - flag_zero and flag_hi update in this cycle and hold until the next retirement.
  - For opcodes 1xx: rf_we=0, flag_err=1 for this cycle only, flag_zero and flag_hi unchanged.
  - Next state: WR_HI if opcode==001, else IDLE, or WR_LO again if a new handshake occurs in this cycle.
- WR_HI cycle:
  - rf_we=1, rf_waddr=(rd+1) mod 2^REG_ADDR_W, rf_wdata=result[31:16].
  - Next state: IDLE, or WR_LO if a new handshake occurs in this cycle.
- in_ready is combinational:
  - 1 in IDLE.
  - 1 in WR_HI.
  - 1 in WR_LO when the held opcode != 001.
  - 0 otherwise.
- Latency and throughput:
  - Handshake at edge N → low write visible in cycle N+1 → high write (mul only) in cycle N+2.
  - Sustained throughput: 1 op/cycle for non-mul, 1 op per 2 cycles for mul.
- rf_* and flag outputs are registered (Moore, driven from state and holding registers). rf_waddr and rf_wdata are 0 whenever rf_we=0.
- Wrap-around: a mul with rd=7 writes its high half to register 0.
- Simultaneous events:
  - A handshake in the final write cycle overwrites the holding registers only after that cycle's write is issued.
  - No bubble is inserted and no write is lost.
- in_valid while in_ready=0: inputs are ignored. Upstream must hold them stable.
- Reset asserted mid-WR_HI: the high half is never written and state goes straight to IDLE.

Decomposition:
- Shared package arith_pkg:
  - Opcode constants OP_ADD=3'b000, OP_MUL=3'b001, OP_SUB=3'b010, OP_DIV=3'b011.
  - FSM state encoding IDLE/WR_LO/WR_HI.
  - Common widths (DATA_W, REG_ADDR_W defaults).
  - The same opcode constants are used by the arithmetic unit.
- One natural sub-module: arith_flag_gen, a combinational block that computes zero, hi and err from the held result and opcode. The FSM and register-file interface stay in arith_wb_stage.

Test Plan:
- Reset mid-op:
  - Stimulus: hold rst high, release; then accept a mul (rd=5) and assert rst in its WR_HI cycle.
  - Response: all outputs 0 after the first reset; after the second, no write to register 6, outputs 0 immediately, busy=0.
- Add retire:
  - Stimulus: opcode 000, result 0x0000_1234, rd=2.
  - Response: one cycle later rf_we=1, addr=2, data=0x1234; flag_zero=0, flag_hi=0; in_ready stays 1.
- Mul two-beat with wrap:
  - Stimulus: opcode 001, result 0xABCD_0123, rd=7.
  - Response: cycle N+1 writes addr 7 data 0x0123; cycle N+2 writes addr 0 data 0xABCD; flag_hi=1; in_ready=0 in WR_LO only.
- Back-to-back:
  - Stimulus: in_valid held high for sub (result 0x0000_0000, rd=1), div (result 5, rd=3), mul (result 0x0002_0004, rd=4), add (result 9, rd=6).
  - Response: writes on consecutive cycles (1←0, 3←5, 4←4, 5←2), then 6←9 one cycle later after a one-cycle stall; flag_zero=1 only after the sub.
- Invalid opcode:
  - Stimulus: opcode 3'b101, result 0.
  - Response: no rf write; flag_err pulses for exactly one cycle; flag_zero and flag_hi keep their previous values.
